mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage ARM pipeline. Sits directly downstream of the execute stage and its EXE/MEM register.
- Consumes the ALU result, Rm value, memory enables, write-back enable and destination register.
- Performs data-memory loads/stores with a configurable multi-cycle access latency and stalls upstream through a ready signal.
- Registers results into the MEM/WB boundary for the write-back stage.

Parameters:
- DEPTH, 64: data memory size in 32-bit words; power of two.
- BASE_ADDR, 1024: byte address mapped to word 0.
- WAIT_CYCLES, 3: access wait states per load/store; legal range 1..15.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rest  input  1  reset, asynchronous, active-high.
- memREn  input  1  load request from EXE/MEM.
- memWEn  input  1  store request from EXE/MEM.
- wbEn  input  1  write-back enable from EXE/MEM.
- dest  input  4  destination register number.
- aluRes  input  32  ALU result; byte address for loads/stores.
- valRm  input  32  store data.
- ready  output  1  0 = freeze PC, IF/ID, ID/EXE and EXE/MEM this cycle.
- wbEnOut  output  1  registered write-back enable.
- wbMemREn  output  1  registered load flag; WB mux selects memData when 1.
- wbDest  output  4  registered destination.
- wbAluRes  output  32  registered ALU result.
- wbMemData  output  32  registered load data.

Behaviour:
Reset
- Reset is asynchronous and active-high (rest). On reset: state=IDLE, wait counter=0, all wb* outputs=0.
- ready reads 1 while in reset.
- Memory contents are not cleared by reset.
- Reset mid-access aborts the access and returns to IDLE. A store whose write has not yet occurred (writes occur only in DONE) never reaches memory.

Addressing
- Word index = ((aluRes - BASE_ADDR) >> 2) truncated to log2(DEPTH) bits, so addresses wrap modulo DEPTH.
- Byte offset bits [1:0] are ignored.

FSM
- IDLE
  - No request (memREn=memWEn=0): ready=1. On the clock edge, the wb* registers capture wbEn, memREn, dest and aluRes; wbMemData gets 0.
  - Request present: ready=0 combinationally, counter loads WAIT_CYCLES-1, next state ACCESS. wb* registers load bubble values (wbEnOut=0, wbMemREn=0).
- ACCESS
  - ready=0 and counter decrements each cycle. Upstream holds its inputs stable.
  - When counter==0, next state DONE.
  - wb* registers continue to load bubbles.
- DONE
  - ready=1.
  - Store: memory[word] <= valRm on this edge.
  - Load: wbMemData <= memory[word], using an asynchronous read of the array.
  - wb* registers capture the inputs as in IDLE. Next state IDLE.
  - The request is consumed once; the next upstream instruction appears in IDLE.

Timing and boundary cases
- Access latency: the request is first seen in cycle 0; ready is low for WAIT_CYCLES cycles and high in cycle WAIT_CYCLES. WB data is visible in cycle WAIT_CYCLES+1.
- memREn and memWEn both asserted: treated as a store, and wbMemREn is forced to 0.
- Back-to-back memory ops: each incurs the full latency, with exactly one DONE cycle between them.
- wbEn=0 with no memory op (e.g. CMP or a branch): passes through as wbEnOut=0 and is harmless.

Decomposition:
- Shared package arm_pkg holds:
  - MEM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - DATA_W=32 and REG_ADDR_W=4.
  - Default BASE_ADDR.
- One sub-module, data_memory: DEPTH-word array, synchronous write with enable, asynchronous read, parameterised by DEPTH.
- The FSM, wait counter and MEM/WB register stay in mem_stage.

Test Plan:
1. Reset then idle ALU op: rest pulse; aluRes=32'h5, dest=4'd3, wbEn=1, no mem op -> ready stays 1; next edge wbEnOut=1, wbDest=3, wbAluRes=5, wbMemREn=0.
2. Store then load, WAIT_CYCLES=3:
   - Store: aluRes=1032, valRm=32'hDEADBEEF, memWEn=1 -> ready=0 for 3 cycles, 1 in the 4th; word 2 then holds DEADBEEF.
   - Load: same address, memREn=1, dest=5 -> after the same stall, wbMemData=DEADBEEF, wbMemREn=1, wbDest=5.
3. Address wrap, DEPTH=64: store 32'h1234 at aluRes=1024+256 -> load from aluRes=1024 returns 32'h1234.
4. Reset mid-access: store issued, rest asserted in ACCESS -> outputs 0 immediately, ready=1, state IDLE; a subsequent load of that address returns the prior contents.
5. Simultaneous memREn=memWEn=1 at 1028 with valRm=7 -> word 1 becomes 7, wbMemREn=0 at completion.
6. Back-to-back loads with WAIT_CYCLES=1 -> ready pattern 0,1,0,1; two distinct wbMemData values appear on consecutive DONE edges, with no duplicated or lost op.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: datapath widths, memory-stage FSM encoding
// and the default data-memory base address.
package arm_pkg;
  localparam int DATA_W            = 32;
  localparam int REG_ADDR_W        = 4;
  localparam int DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_stage_if.sv
// EXE/MEM inputs, the upstream stall and the MEM/WB outputs of the memory stage.
interface mem_stage_if;
  import arm_pkg::*;

  logic                  memREn;
  logic                  memWEn;
  logic                  wbEn;
  logic [REG_ADDR_W-1:0] dest;
  logic [DATA_W-1:0]     aluRes;
  logic [DATA_W-1:0]     valRm;
  logic                  ready;
  logic                  wbEnOut;
  logic                  wbMemREn;
  logic [REG_ADDR_W-1:0] wbDest;
  logic [DATA_W-1:0]     wbAluRes;
  logic [DATA_W-1:0]     wbMemData;

  modport master (
    output memREn, memWEn, wbEn, dest, aluRes, valRm,
    input  ready, wbEnOut, wbMemREn, wbDest, wbAluRes, wbMemData
  );

  modport slave (
    input  memREn, memWEn, wbEn, dest, aluRes, valRm,
    output ready, wbEnOut, wbMemREn, wbDest, wbAluRes, wbMemData
  );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_memory
  import arm_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// ARM pipeline memory stage: multi-cycle load/store with upstream stall and
// the MEM/WB pipeline register.
module mem_stage
  import arm_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rest,
  mem_stage_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

  mem_state_t            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  en_reg, en_next;
  logic                  rd_reg, rd_next;
  logic [REG_ADDR_W-1:0] dest_reg, dest_next;
  logic [DATA_W-1:0]     alu_reg, alu_next;
  logic [DATA_W-1:0]     data_reg, data_next;
  logic                  ready_comb;
  logic                  mem_we;
  logic [DATA_W-1:0]     offset;
  logic [AW-1:0]         word_idx;
  logic [DATA_W-1:0]     rdata;
  logic                  req, is_store, is_load;

  assign offset   = bus.aluRes - DATA_W'(BASE_ADDR);
  assign word_idx = AW'(offset >> 2);
  assign req      = bus.memREn | bus.memWEn;
  assign is_store = bus.memWEn;
  assign is_load  = bus.memREn & ~bus.memWEn;

  data_memory #(.DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (bus.valRm),
    .rdata (rdata)
  );

  // cnt_reg holds the stall cycles still owed, counting the current ACCESS
  // cycle, so ready is low for exactly WAIT_CYCLES cycles before DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready_comb = 1'b1;
    mem_we     = 1'b0;
    en_next    = 1'b0;
    rd_next    = 1'b0;
    dest_next  = '0;
    alu_next   = '0;
    data_next  = '0;
    unique case (state_reg)
      MEM_IDLE: begin
        if (req) begin
          ready_comb = 1'b0;
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_CYCLES == 1) ? MEM_DONE : MEM_ACCESS;
        end else begin
          en_next   = bus.wbEn;
          rd_next   = bus.memREn;
          dest_next = bus.dest;
          alu_next  = bus.aluRes;
        end
      end
      MEM_ACCESS: begin
        ready_comb = 1'b0;
        cnt_next   = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) state_next = MEM_DONE;
      end
      MEM_DONE: begin
        mem_we     = is_store;
        en_next    = bus.wbEn;
        rd_next    = is_load;
        dest_next  = bus.dest;
        alu_next   = bus.aluRes;
        data_next  = is_load ? rdata : '0;
        cnt_next   = '0;
        state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_reg <= MEM_IDLE;
      cnt_reg   <= '0;
      en_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      dest_reg  <= '0;
      alu_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      en_reg    <= en_next;
      rd_reg    <= rd_next;
      dest_reg  <= dest_next;
      alu_reg   <= alu_next;
      data_reg  <= data_next;
    end
  end

  assign bus.ready     = rest | ready_comb;
  assign bus.wbEnOut   = en_reg;
  assign bus.wbMemREn  = rd_reg;
  assign bus.wbDest    = dest_reg;
  assign bus.wbAluRes  = alu_reg;
  assign bus.wbMemData = data_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one instance with 3 wait states, one with 1.
module tb_mem_stage;
  typedef struct packed {
    logic        en;
    logic        mrd;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rest = 1'b0;
  logic sel = 1'b0;
  logic mem_r = 1'b0, mem_w = 1'b0, wb_en = 1'b0;
  logic [3:0]  dest_v = '0;
  logic [31:0] alu_v = '0, rm_v = '0;

  logic [31:0] model3 [64];
  logic [31:0] model1 [64];
  wb_t sb [$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_stage_if bus3 ();
  mem_stage_if bus1 ();

  assign bus3.memREn = mem_r & ~sel;
  assign bus3.memWEn = mem_w & ~sel;
  assign bus3.wbEn   = wb_en;
  assign bus3.dest   = dest_v;
  assign bus3.aluRes = alu_v;
  assign bus3.valRm  = rm_v;
  assign bus1.memREn = mem_r & sel;
  assign bus1.memWEn = mem_w & sel;
  assign bus1.wbEn   = wb_en;
  assign bus1.dest   = dest_v;
  assign bus1.aluRes = alu_v;
  assign bus1.valRm  = rm_v;

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rest(rest), .bus(bus3.slave));
  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rest(rest), .bus(bus1.slave));

  logic        rdy, o_en, o_rd;
  logic [3:0]  o_dest;
  logic [31:0] o_alu, o_data;
  assign rdy    = sel ? bus1.ready     : bus3.ready;
  assign o_en   = sel ? bus1.wbEnOut   : bus3.wbEnOut;
  assign o_rd   = sel ? bus1.wbMemREn  : bus3.wbMemREn;
  assign o_dest = sel ? bus1.wbDest    : bus3.wbDest;
  assign o_alu  = sel ? bus1.wbAluRes  : bus3.wbAluRes;
  assign o_data = sel ? bus1.wbMemData : bus3.wbMemData;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) >> 2;
    return int'(w[5:0]);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the op's WB capture.
  task automatic run_op(input logic rd, input logic wr, input logic wbe,
                        input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
    wb_t exp, got;
    int lows, stall;
    mem_r = rd; mem_w = wr; wb_en = wbe; dest_v = d; alu_v = a; rm_v = v;
    exp.en = wbe; exp.dest = d; exp.alu = a;
    exp.mrd = rd & ~wr;
    exp.data = '0;
    if (wr) begin
      if (sel) model1[word_of(a)] = v; else model3[word_of(a)] = v;
    end else if (rd) begin
      exp.data = sel ? model1[word_of(a)] : model3[word_of(a)];
    end
    sb.push_back(exp);
    stall = (rd | wr) ? (sel ? 1 : 3) : 0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy) break;
      lows++;
    end
    check_value("stall_cycles", lows, stall);
    @(posedge clk); #1;
    got = '{en: o_en, mrd: o_rd, dest: o_dest, alu: o_alu, data: o_data};
    exp = sb.pop_front();
    check_value("wbEnOut", got.en, exp.en);
    check_value("wbMemREn", got.mrd, exp.mrd);
    check_value("wbDest", got.dest, exp.dest);
    check_value("wbAluRes", got.alu, exp.alu);
    check_value("wbMemData", got.data, exp.data);
    $display("[TB] inst=%0d rd=%0d wr=%0d addr=%0d stall=%0d -> en=%0d mrd=%0d dest=%0d data=%h",
             sel ? 1 : 3, rd, wr, a, lows, got.en, got.mrd, got.dest, got.data);
  endtask

  task automatic go_idle();
    mem_r = 0; mem_w = 0; wb_en = 0; dest_v = '0; alu_v = '0; rm_v = '0;
  endtask

  initial begin
    // Reset, with a request pending to show ready stays high while in reset
    rest = 1'b1;
    mem_w = 1'b1; alu_v = 32'd1032;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_ready", rdy, 1);
    check_value("rst_wbEnOut", o_en, 0);
    check_value("rst_wbAluRes", o_alu, 0);
    check_value("rst_wbMemData", o_data, 0);
    go_idle();
    rest = 1'b0;
    @(posedge clk); #1;

    // Plain ALU op, then store/load through the 3-wait-state instance
    run_op(0, 0, 1, 4'd3, 32'h5, 32'h0);
    run_op(0, 1, 0, 4'd0, 32'd1032, 32'hDEADBEEF);
    run_op(1, 0, 1, 4'd5, 32'd1032, 32'h0);
    run_op(1, 0, 1, 4'd6, 32'd1035, 32'h0);
    // Address wrap: 1024+256 aliases word 0
    run_op(0, 1, 0, 4'd0, 32'd1280, 32'h1234);
    run_op(1, 0, 1, 4'd7, 32'd1024, 32'h0);
    // Both enables: store wins, load flag suppressed
    run_op(1, 1, 1, 4'd8, 32'd1028, 32'd7);
    run_op(1, 0, 1, 4'd9, 32'd1028, 32'h0);
    // Compare/branch style op with no write-back
    run_op(0, 0, 0, 4'd2, 32'hFFFF_0000, 32'h0);

    // Reset while the store is in ACCESS: the write must never land
    mem_w = 1'b1; wb_en = 1'b0; alu_v = 32'd1032; rm_v = 32'h0000CAFE;
    @(negedge clk);
    @(negedge clk);
    #1 rest = 1'b1;
    #1;
    check_value("midrst_ready", rdy, 1);
    check_value("midrst_wbEnOut", o_en, 0);
    check_value("midrst_wbMemData", o_data, 0);
    go_idle();
    #2 rest = 1'b0;
    @(posedge clk); #1;
    run_op(1, 0, 1, 4'd4, 32'd1032, 32'h0);

    // Single-wait-state instance: back-to-back stores, then back-to-back loads
    sel = 1'b1;
    go_idle();
    @(posedge clk); #1;
    run_op(0, 1, 0, 4'd0, 32'd1040, 32'hA5A5_0001);
    run_op(0, 1, 0, 4'd0, 32'd1044, 32'h5A5A_0002);
    run_op(1, 0, 1, 4'd10, 32'd1040, 32'h0);
    run_op(1, 0, 1, 4'd11, 32'd1044, 32'h0);
    run_op(0, 0, 1, 4'd12, 32'h77, 32'h0);
    go_idle();

    check_value("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
